// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeouts and ecall halt.
// Define SEQ_PERF_CNT_EN to build the cycle_cnt/instret performance counters.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             RegWrite,
  input  logic             ecall,
  input  logic             branch_taken,
  input  logic             jal,
  input  logic             jalr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StErr    = 3'd7
  } state_e;

  localparam bit               TimeoutEn   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             wait_expired;

  // The wait cycle that brings the count to MEM_TIMEOUT is the last one allowed.
  assign wait_expired = TimeoutEn && (wait_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      StDecode: begin
        state_d = ecall ? StHalt : StExec;
      end
      StExec: begin
        state_d = (MemtoReg | MemWrite) ? StMem : StWb;
      end
      StMem: begin
        if (dmem_ack) begin
          state_d = StWb;
        end else if (wait_expired) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      StWb: begin
        state_d = run ? StFetch : StIdle;
      end
      StHalt: begin
        if (!run) state_d = StIdle;
      end
      StErr: begin
        state_d = StErr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state    = state_q;
  assign imem_req = (state_q == StFetch);
  assign ir_we    = (state_q == StFetch) & imem_ack;
  assign dmem_req = (state_q == StMem);
  assign dmem_we  = (state_q == StMem) & MemWrite;
  assign pc_we    = (state_q == StWb);
  assign pc_sel   = (state_q == StWb) & (branch_taken | jal | jalr);
  assign rf_we    = (state_q == StWb) & RegWrite;
  assign halted   = (state_q == StHalt);
  assign bus_err  = (state_q == StErr);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             active;

  assign active = state_q inside {StFetch, StDecode, StExec, StMem, StWb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (active) cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == StWb) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle state/strobe trace and perf counts.
module tb_multicycle_sequencer;

  localparam int MemTimeout = 15;
  localparam int CntW       = 8;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam int KAlu = 0, KLoad = 1, KStore = 2, KBranch = 3, KJal = 4, KJalr = 5, KEcall = 6;
  localparam int Never = 1000;

  // Expected-flag bits, order matches the observed vector below.
  localparam logic [8:0] FImReq = 9'h100, FIrWe = 9'h080, FDReq = 9'h040, FDWe  = 9'h020;
  localparam logic [8:0] FPcWe  = 9'h010, FPcSel = 9'h008, FRfWe = 9'h004, FHalt = 9'h002;
  localparam logic [8:0] FErr   = 9'h001, FNone = 9'h000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            run = 1'b0;
  logic            mem_to_reg = 1'b0, mem_write = 1'b0, reg_write = 1'b0, ecall = 1'b0;
  logic            branch_taken = 1'b0, jal = 1'b0, jalr = 1'b0;
  logic            imem_ack = 1'b0, dmem_ack = 1'b0;
  logic            imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, halted, bus_err;
  logic [2:0]      state;
  logic [CntW-1:0] cycle_cnt, instret;

  int unsigned     n_tests = 0, n_fail = 0;
  logic [CntW-1:0] m_cyc = '0, m_ret = '0;
  bit              m_idle = 1'b1;
  logic [6:0]      dec = '0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .MemtoReg    (mem_to_reg),
    .MemWrite    (mem_write),
    .RegWrite    (reg_write),
    .ecall       (ecall),
    .branch_taken(branch_taken),
    .jal         (jal),
    .jalr        (jalr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .halted      (halted),
    .bus_err     (bus_err),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .instret     (instret)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] observed();
    return {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, halted, bus_err};
  endfunction

  task automatic check_perf();
    check_eq("cycle_cnt", 32'(cycle_cnt), 32'(PerfEn ? m_cyc : '0));
    check_eq("instret", 32'(instret), 32'(PerfEn ? m_ret : '0));
  endtask

  // One clock: drive inputs (decoder garbage unless held), check at negedge, advance.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [8:0] fl,
                     input logic ia, input logic da, input logic hold);
    imem_ack = ia;
    dmem_ack = da;
    if (hold) {mem_to_reg, mem_write, reg_write, ecall, branch_taken, jal, jalr} = dec;
    else      {mem_to_reg, mem_write, reg_write, ecall, branch_taken, jal, jalr} = 7'($urandom);
    @(negedge clk);
    check_eq(tag, 32'(observed()), 32'({st, fl}));
    if (st >= 3'd1 && st <= 3'd5) m_cyc = m_cyc + CntW'(1);
    if (st == 3'd5) m_ret = m_ret + CntW'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(observed()), 32'd0);
    check_eq("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check_eq("reset_instret", 32'(instret), 32'd0);
    m_cyc  = '0;
    m_ret  = '0;
    m_idle = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic err_tail();
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom);
      cyc("err_sticky", 3'd7, FErr, 1'($urandom), 1'($urandom), 1'b0);
    end
    check_perf();
  endtask

  // fd/md: ack-less cycles before the ack; drop: run falls at this cycle index.
  task automatic do_instr(input int kind, input int fd, input int md, input int drop,
                          input logic br_in);
    logic ld, sto, rw, ec, br, j, jr;
    int   k;
    k   = 0;
    ld  = (kind == KLoad);
    sto = (kind == KStore);
    ec  = (kind == KEcall);
    j   = (kind == KJal);
    jr  = (kind == KJalr);
    br  = (kind == KBranch) ? br_in : 1'b0;
    rw  = (kind == KAlu) || (kind == KLoad) || (kind == KJal) || (kind == KJalr);
    dec = {ld, sto, rw, ec, br, j, jr};
    if (m_idle) begin
      run = 1'b0;
      cyc("idle_hold", 3'd0, FNone, 1'($urandom), 1'($urandom), 1'b0);
      run = 1'b1;
      cyc("idle_start", 3'd0, FNone, 1'($urandom), 1'($urandom), 1'b0);
      m_idle = 1'b0;
    end
    for (int i = 0; i < fd && i < MemTimeout; i++) begin
      run = (k < drop); k++;
      cyc("fetch_wait", 3'd1, FImReq, 1'b0, 1'($urandom), 1'b0);
    end
    if (fd >= MemTimeout) begin
      err_tail();
      return;
    end
    run = (k < drop); k++;
    cyc("fetch_ack", 3'd1, FImReq | FIrWe, 1'b1, 1'($urandom), 1'b0);
    run = (k < drop); k++;
    cyc("decode", 3'd2, FNone, 1'($urandom), 1'($urandom), 1'b1);
    if (ec) begin
      run = 1'b1;
      cyc("halt", 3'd6, FHalt, 1'($urandom), 1'($urandom), 1'b0);
      cyc("halt_hold", 3'd6, FHalt, 1'($urandom), 1'($urandom), 1'b0);
      run = 1'b0;
      cyc("halt_release", 3'd6, FHalt, 1'($urandom), 1'($urandom), 1'b0);
      cyc("idle_after_halt", 3'd0, FNone, 1'($urandom), 1'($urandom), 1'b0);
      m_idle = 1'b1;
      check_perf();
      return;
    end
    run = (k < drop); k++;
    cyc("exec", 3'd3, FNone, 1'($urandom), 1'($urandom), 1'b1);
    if (ld || sto) begin
      for (int i = 0; i < md && i < MemTimeout; i++) begin
        run = (k < drop); k++;
        cyc("mem_wait", 3'd4, FDReq | (sto ? FDWe : FNone), 1'($urandom), 1'b0, 1'b1);
      end
      if (md >= MemTimeout) begin
        err_tail();
        return;
      end
      run = (k < drop); k++;
      cyc("mem_ack", 3'd4, FDReq | (sto ? FDWe : FNone), 1'($urandom), 1'b1, 1'b1);
    end
    run = (k < drop); k++;
    cyc("wb", 3'd5, FPcWe | ((br || j || jr) ? FPcSel : FNone) | (rw ? FRfWe : FNone),
        1'($urandom), 1'($urandom), 1'b1);
    m_idle = !run;
    check_perf();
  endtask

  initial begin
    #2;
    do_reset();

    // Directed: ALU, store with 3-cycle dmem, branches, ecall.
    do_instr(KAlu, 0, 0, Never, 1'b0);
    check_eq("alu_next_fetch", 32'(state), 32'd1);
    do_reset();
    do_instr(KStore, 0, 2, Never, 1'b0);
    check_eq("sw_total_cycles", 32'(cycle_cnt), 32'(PerfEn ? 7 : 0));
    check_eq("sw_instret", 32'(instret), 32'(PerfEn ? 1 : 0));
    do_instr(KBranch, 0, 0, Never, 1'b1);
    do_instr(KBranch, 1, 0, Never, 1'b0);
    do_instr(KJalr, 0, 0, 2, 1'b0);
    do_instr(KEcall, 0, 0, Never, 1'b0);
    do_instr(KAlu, MemTimeout - 1, 0, Never, 1'b0);
    do_instr(KLoad, 0, MemTimeout - 1, Never, 1'b0);

    // Random instruction stream; perf counters wrap several times at CntW=8.
    for (int n = 0; n < 150; n++) begin
      int kind, fd, md, drop;
      kind = int'($urandom_range(6, 0));
      fd   = ($urandom_range(9, 0) == 0) ? int'($urandom_range(MemTimeout - 1, 4)) :
                                            int'($urandom_range(3, 0));
      md   = int'($urandom_range(4, 0));
      drop = ($urandom_range(4, 0) == 0) ? int'($urandom_range(6, 0)) : Never;
      do_instr(kind, fd, md, drop, 1'($urandom));
    end

    // Reset asserted while a load waits in MEM.
    if (m_idle) begin
      run = 1'b1;
      cyc("rst_idle", 3'd0, FNone, 1'b0, 1'b0, 1'b0);
    end
    dec = 7'b1010000;
    run = 1'b1;
    cyc("rst_fetch", 3'd1, FImReq | FIrWe, 1'b1, 1'b0, 1'b0);
    cyc("rst_decode", 3'd2, FNone, 1'b0, 1'b0, 1'b1);
    cyc("rst_exec", 3'd3, FNone, 1'b0, 1'b0, 1'b1);
    cyc("rst_mem_wait", 3'd4, FDReq, 1'b0, 1'b0, 1'b1);
    check_eq("rst_mem_req_before", 32'(dmem_req), 32'd1);
    do_reset();

    // Timeouts: imem then dmem never ack.
    do_instr(KAlu, MemTimeout, 0, Never, 1'b0);
    do_reset();
    do_instr(KStore, 0, MemTimeout + 5, Never, 1'b0);
    do_reset();
    do_instr(KAlu, 0, 0, Never, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
